spi_mem_responder: RTL

- SPI target (mode 0) that answers the serial-SRAM command subset our bus master issues: READ 0x03 and WRITE 0x02, each followed by an address and streamed data bytes.
- Sits on the target side of the SPI link and bridges to a byte-wide synchronous memory port. It stands in for the external RAM in system simulation and can be reused as an on-chip SPI-accessible buffer.
- All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_mem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_responder.sv
// SPI mode-0 target that bridges serial-SRAM READ (0x03) / WRITE (0x02) commands onto a
// byte-wide synchronous memory port; SPI pins are oversampled in the clk domain (clk >= 8x sclk).
//
// state  | meaning
// IDLE   | deselected, or selected before a fresh cs_n falling edge
// CMD    | shifting in the command byte
// ADDR   | shifting in the address; read prefetch issued after the last bit
// READ   | streaming memory bytes out on miso
// WRITE  | writing each received byte to memory
// IGNORE | unknown command, waits for cs_n to rise
module spi_mem_responder #(
    parameter int ADDR_BYTES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sclk,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    output logic [8*ADDR_BYTES-1:0]   mem_addr,
    output logic                      mem_re,
    input  logic [7:0]                mem_rdata,
    output logic                      mem_we,
    output logic [7:0]                mem_wdata,
    output logic                      busy,
    output logic                      bad_cmd
);

    localparam int AW  = 8 * ADDR_BYTES;
    localparam int BCW = $clog2(ADDR_BYTES + 1);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, sync_valid;
    logic sclk_prev, cs_prev, armed;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall;

    logic [2:0]     bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [7:0]     rx_sr, tx_sr, rx_byte;
    logic           is_read, skip_fall, rd_valid;
    logic           byte_done, last_addr_bit, cmd_ok;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    // armed blocks a transaction that was already selected when reset was released
    assign cs_fall   = cs_prev & ~cs_s & armed;

    assign rx_byte       = {rx_sr[6:0], mosi_s};
    assign byte_done     = sclk_rise && (bit_cnt == 3'd7);
    assign last_addr_bit = (state == S_ADDR) && byte_done && (byte_cnt == BCW'(ADDR_BYTES - 1));
    assign cmd_ok        = (rx_byte == CMD_READ) || (rx_byte == CMD_WRITE);

    assign miso    = tx_sr[7];
    assign miso_oe = (state == S_READ) && !cs_s;
    assign busy    = ~cs_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            sync_valid <= '0;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
            armed      <= 1'b0;
        end else begin
            sclk_sync  <= (sclk_sync << 1) | SYNC_STAGES'(sclk);
            cs_sync    <= (cs_sync << 1) | SYNC_STAGES'(cs_n);
            mosi_sync  <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
            sync_valid <= (sync_valid << 1) | SYNC_STAGES'(1);
            sclk_prev  <= sclk_s;
            cs_prev    <= cs_s;
            armed      <= armed | (sync_valid[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_s) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (cs_fall) state_nx = S_CMD;
                S_CMD:   if (byte_done) state_nx = cmd_ok ? S_ADDR : S_IGNORE;
                S_ADDR: begin
                    if (is_read) begin
                        if (rd_valid) state_nx = S_READ;
                    end else if (last_addr_bit) begin
                        state_nx = S_WRITE;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            is_read   <= 1'b0;
            skip_fall <= 1'b0;
            rd_valid  <= 1'b0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            bad_cmd   <= 1'b0;
        end else begin
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            bad_cmd  <= 1'b0;
            rd_valid <= mem_re;
            if (mem_we) mem_addr <= mem_addr + AW'(1);
            if (cs_s) begin
                bit_cnt   <= '0;
                byte_cnt  <= '0;
                rx_sr     <= '0;
                tx_sr     <= '0;
                skip_fall <= 1'b0;
            end else begin
                if (sclk_rise && state != S_IDLE) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte;
                end
                case (state)
                    S_CMD: begin
                        if (byte_done) begin
                            is_read <= (rx_byte == CMD_READ);
                            bad_cmd <= !cmd_ok;
                        end
                    end
                    S_ADDR: begin
                        if (sclk_rise) begin
                            mem_addr <= {mem_addr[AW-2:0], mosi_s};
                            if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + BCW'(1);
                            if (last_addr_bit) begin
                                mem_re    <= is_read;
                                skip_fall <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        // the fall right after a byte boundary presents the freshly loaded MSB
                        if (byte_done) begin
                            mem_addr  <= mem_addr + AW'(1);
                            mem_re    <= 1'b1;
                            skip_fall <= 1'b1;
                        end else if (sclk_fall) begin
                            if (skip_fall) skip_fall <= 1'b0;
                            else           tx_sr     <= {tx_sr[6:0], 1'b0};
                        end
                    end
                    S_WRITE: begin
                        if (byte_done) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= rx_byte;
                        end
                    end
                    default: ;
                endcase
                if (rd_valid) tx_sr <= mem_rdata;
            end
        end
    end

endmodule
